uart_rx_core: RTL
=================

# uart_rx_core

Serial receiver for 8N1 UART frames: 8 data bits, LSB first, one start bit, one stop bit, no parity unless configured. It is the receive-side counterpart of the team's UART transmitter and uses the same CLKS_PER_BIT timing, so the two interoperate on one baud setting. It synchronises the asynchronous serial input, validates the start bit, samples each bit at mid-bit and delivers the byte with a one-cycle valid strobe or a framing-error strobe. It sits between the board RX pin and the host-side command/FIFO logic.

## Interface
- CLKS_PER_BIT, 87: clock cycles per serial bit, (i_Clock freq)/(baud); legal range 4..511.
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Rx_Serial  in  1  raw serial line; idle high; asynchronous to i_Clock.
- o_Rx_DV  out  1  one-cycle pulse: o_Rx_Byte holds a good frame.
- o_Rx_Byte  out  8  last received byte; held until the next frame completes.
- o_Rx_Frame_Err  out  1  one-cycle pulse: stop bit sampled low.
- o_Rx_Parity_Err  out  1  one-cycle pulse: parity mismatch (only with UART_RX_PARITY_EN).
- o_Rx_Active  out  1  high from start-bit detect until the state machine leaves STOP.
- o_Rx_Idle  out  1  high while in IDLE.

## Operation
- Reset (asynchronous, active-low): state IDLE; both synchroniser flops 1; counters 0; o_Rx_Byte 0x00; o_Rx_DV, o_Rx_Frame_Err, o_Rx_Parity_Err, o_Rx_Active 0; o_Rx_Idle 1.
- i_Rx_Serial passes through a 2-flop synchroniser; all decisions use the synchronised bit (rx_s).
- Clock counter is 9 bits; it counts 0..CLKS_PER_BIT-1 per bit.
- States are IDLE, START, DATA, PARITY (macro only), STOP and CLEANUP.
- IDLE: counter and bit index are 0. When rx_s = 0: o_Rx_Active goes to 1 and the state goes to START.
- START: counts to (CLKS_PER_BIT-1)/2 (integer division), i.e. mid start bit.
  - If rx_s = 0 there: counter goes to 0 and the state goes to DATA.
  - Otherwise the event is a glitch: state goes to IDLE, o_Rx_Active goes to 0, no strobe.
- DATA: waits until counter = CLKS_PER_BIT-1, then samples rx_s into shift bit [index], LSB first. After bit 7 the state goes to PARITY or STOP.
- PARITY: one bit period, then samples rx_s. Even parity: XOR of the data bits and the parity bit must equal 0.
- STOP: one bit period, then samples rx_s.
  - rx_s = 1: load o_Rx_Byte and pulse o_Rx_DV. If parity failed, pulse o_Rx_Parity_Err in the same cycle as o_Rx_DV.
  - rx_s = 0: pulse o_Rx_Frame_Err. o_Rx_Byte is not updated and o_Rx_DV is not asserted.
  - In both cases o_Rx_Active goes to 0 and the state goes to CLEANUP.
- CLEANUP: lasts one cycle, then the state goes to IDLE. If rx_s is still 0 (a break or a stuck-low line), the block stays in IDLE until rx_s = 1 before arming the start detect again. This prevents false frames during a break.
- Unused state encodings go to IDLE.

## Timing
- Synchroniser latency: 2 cycles from a pin edge to rx_s.
- Start-detect cycle is called T0.
- Start-bit check happens at T0+(CLKS_PER_BIT-1)/2+1.
- Each later sample happens exactly CLKS_PER_BIT cycles after the previous one.
- o_Rx_DV and o_Rx_Frame_Err are registered. They are high in the cycle after the stop sample, for exactly 1 cycle.
- Pin falling edge to o_Rx_DV: 2 + 1 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles without parity; add CLKS_PER_BIT with parity.
- Back-to-back frames, with the next start bit immediately after the stop bit, must be received without loss.
- Reset asserted mid-frame aborts the frame immediately, with no strobe.

## Configuration
- UART_RX_PARITY_EN defined:
  - The PARITY state is compiled in.
  - The frame is 8E1.
  - o_Rx_Parity_Err is driven as described in Operation.
- UART_RX_PARITY_EN undefined:
  - There is no PARITY state and the frame is 8N1.
  - o_Rx_Parity_Err is tied to 0.

## Test plan
- Reset, then i_Rx_Serial held high for 100 cycles -> o_Rx_Idle = 1, no strobes, o_Rx_Byte = 0x00.
- CLKS_PER_BIT = 16, send 8N1 frame 0xA5 -> one o_Rx_DV pulse, o_Rx_Byte = 0xA5, o_Rx_Frame_Err = 0, DV at the computed cycle.
- Low glitch of 5 cycles on an idle line (CLKS_PER_BIT = 16) -> return to IDLE, no o_Rx_DV, no error pulse.
- Frame 0x3C with the stop bit driven low -> o_Rx_Frame_Err pulses once, o_Rx_Byte unchanged, no o_Rx_DV. Line held low for 40 bit times then released, followed by frame 0x81 -> only 0x81 is received.
- Frames 0x00, 0xFF, 0x55 sent back-to-back with no idle gap -> three o_Rx_DV pulses in order, with the correct bytes.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 0, which is wrong -> o_Rx_DV and o_Rx_Parity_Err pulse together, o_Rx_Byte = 0x07. Reset asserted mid-DATA in any build -> outputs return to their reset values and no strobe occurs.

Source files
------------

// File: rtl/uart_rx_core_if.sv
// Signal bundle between the UART receive core and its host-side consumer.
// master: the receiver core (samples the line, drives the strobes and byte).
// slave:  the line driver / host logic observing the received data.
interface uart_rx_core_if;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Frame_Err;
    logic       o_Rx_Parity_Err;
    logic       o_Rx_Active;
    logic       o_Rx_Idle;

    modport master (
        input  i_Rx_Serial,
        output o_Rx_DV,
        output o_Rx_Byte,
        output o_Rx_Frame_Err,
        output o_Rx_Parity_Err,
        output o_Rx_Active,
        output o_Rx_Idle
    );

    modport slave (
        output i_Rx_Serial,
        input  o_Rx_DV,
        input  o_Rx_Byte,
        input  o_Rx_Frame_Err,
        input  o_Rx_Parity_Err,
        input  o_Rx_Active,
        input  o_Rx_Idle
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Synchronises the serial line, validates the start bit at mid-bit, samples each
// following bit at mid-bit and reports a good byte or a framing/parity error strobe.
module uart_rx_core #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic            i_Clock,
    input  logic            i_Rst_n,
    uart_rx_core_if.master  rx_if
);
    localparam logic [8:0] HalfBit = 9'((CLKS_PER_BIT - 1) / 2);
    localparam logic [8:0] LastCnt = 9'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StStart   = 3'd1,
        StData    = 3'd2,
`ifdef UART_RX_PARITY_EN
        StParity  = 3'd3,
`endif
        StStop    = 3'd4,
        StCleanup = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] sync_q;
    logic       rx_s;
    logic [8:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       dv_q, dv_d;
    logic       ferr_q, ferr_d;
    logic       active_q, active_d;
    // Cleared when a frame ends on a low line; start detect waits for the line to go high.
    logic       armed_q, armed_d;
`ifdef UART_RX_PARITY_EN
    logic       par_bad_q, par_bad_d;
    logic       perr_q, perr_d;
`endif

    assign rx_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous serial pin
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], rx_if.i_Rx_Serial};
    end

    // State and datapath registers
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            ferr_q    <= 1'b0;
            active_q  <= 1'b0;
            armed_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            ferr_q    <= ferr_d;
            active_q  <= active_d;
            armed_q   <= armed_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    // Next-state logic: bit timing, sampling and strobe generation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        dv_d      = 1'b0;
        ferr_d    = 1'b0;
        active_d  = active_q;
        armed_d   = armed_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (!armed_q) begin
                    if (rx_s) armed_d = 1'b1;
                end else if (!rx_s) begin
                    active_d = 1'b1;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfBit) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = StData;
                    end else begin
                        state_d  = StIdle;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            StData: begin
                if (cnt_q == LastCnt) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == LastCnt) begin
                    cnt_d     = '0;
                    par_bad_d = ^{shift_q, rx_s};
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
`endif
            StStop: begin
                if (cnt_q == LastCnt) begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                    state_d  = StCleanup;
                    if (rx_s) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d = par_bad_q;
`endif
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            StCleanup: begin
                armed_d = rx_s;
                state_d = StIdle;
            end
            default: begin
                state_d  = StIdle;
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
            end
        endcase
    end

    assign rx_if.o_Rx_DV        = dv_q;
    assign rx_if.o_Rx_Byte      = byte_q;
    assign rx_if.o_Rx_Frame_Err = ferr_q;
    assign rx_if.o_Rx_Active    = active_q;
    assign rx_if.o_Rx_Idle      = (state_q == StIdle);
`ifdef UART_RX_PARITY_EN
    assign rx_if.o_Rx_Parity_Err = perr_q;
`else
    assign rx_if.o_Rx_Parity_Err = 1'b0;
`endif
endmodule
